// File: rtl/knn_ctrl.sv
// k-NN classification sequencer: streams N dataset points past a distance sorter, then collects 4 results.
// Latency: 3N+6 cycles from start (inclusive) to the done pulse; mem data expected one cycle after mem_rd.
// Backpressure: none; memory and sorter are assumed always ready, and start is ignored while busy.
//
// Optional feature: define KNN_CTRL_ABORT_EN to add the abort input (cancel a run, return to IDLE).
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start, n_points    run request and dataset size, sampled in IDLE only
//   test_x, test_y     test point, latched with start onto s_x1/s_y1
//   busy, done         high outside IDLE / one-cycle completion pulse
//   mem_rd, mem_addr   dataset read strobe and index; mem_x/mem_y return next cycle
//   s_ready            one-cycle push of (s_x1,s_y1)-(s_x2,s_y2) into the sorter
//   s_done, s_sel      result read-out phase, s_sel steps 0..3
//   s_data_out         sorter result for the current s_sel
//   res_sel, res_out   combinational read of captured result register res[res_sel]
module knn_ctrl (
    input  logic               clk,
    input  logic               rst,
`ifdef KNN_CTRL_ABORT_EN
    input  logic               abort,
`endif
    input  logic               start,
    input  logic [7:0]         n_points,
    input  logic signed [15:0] test_x,
    input  logic signed [15:0] test_y,
    output logic               busy,
    output logic               done,
    output logic               mem_rd,
    output logic [7:0]         mem_addr,
    input  logic signed [15:0] mem_x,
    input  logic signed [15:0] mem_y,
    output logic               s_ready,
    output logic               s_done,
    output logic [1:0]         s_sel,
    output logic signed [15:0] s_x1,
    output logic signed [15:0] s_y1,
    output logic signed [15:0] s_x2,
    output logic signed [15:0] s_y2,
    input  logic [7:0]         s_data_out,
    input  logic [1:0]         res_sel,
    output logic [7:0]         res_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CAPT  = 3'd2,
        PUSH  = 3'd3,
        READ  = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  idx;
    logic [7:0]  n_pts;
    logic [7:0]  res [4];
    logic        abort_hit;
    logic        last_pt;

`ifdef KNN_CTRL_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Compare in 9 bits so idx+1 cannot wrap when N=255.
    assign last_pt = ({1'b0, idx} + 9'd1) >= {1'b0, n_pts};

    // Control outputs are pure decodes of the state register.
    assign busy     = (state != IDLE);
    assign mem_rd   = (state == FETCH);
    assign s_ready  = (state == PUSH);
    assign s_done   = (state == READ);
    assign done     = (state == FIN);
    assign mem_addr = idx;
    assign res_out  = res[res_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (n_points != 8'd0) ? FETCH : READ;
                end
            end
            FETCH: state_nxt = CAPT;
            CAPT:  state_nxt = PUSH;
            PUSH:  state_nxt = last_pt ? READ : FETCH;
            READ:  state_nxt = (s_sel == 2'd3) ? FIN : READ;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= 8'd0;
            n_pts <= 8'd0;
            s_sel <= 2'd0;
            s_x1  <= 16'sd0;
            s_y1  <= 16'sd0;
            s_x2  <= 16'sd0;
            s_y2  <= 16'sd0;
            for (int k = 0; k < 4; k++) begin
                res[k] <= 8'd0;
            end
        end else if (abort_hit) begin
            // Abandon the run; results from the last completed run are kept.
            s_sel <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        s_x1  <= test_x;
                        s_y1  <= test_y;
                        n_pts <= n_points;
                        idx   <= 8'd0;
                    end
                end
                CAPT: begin
                    s_x2 <= mem_x;
                    s_y2 <= mem_y;
                end
                PUSH: begin
                    idx <= idx + 8'd1;
                end
                READ: begin
                    res[s_sel] <= s_data_out;
                    // Wraps 3 -> 0 on the last READ cycle, so FIN presents s_sel=0.
                    s_sel      <= s_sel + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_ctrl.sv
// Directed bench for knn_ctrl: memory model with one-cycle read latency, sorter model returning sort_base+s_sel.
// Cycle numbering: the cycle in which start is first driven is cycle 1, so done lands in cycle 3N+6.
module tb_knn_ctrl;

    logic               clk;
    logic               rst;
    logic               start;
    logic [7:0]         n_points;
    logic signed [15:0] test_x;
    logic signed [15:0] test_y;
    logic               busy;
    logic               done;
    logic               mem_rd;
    logic [7:0]         mem_addr;
    logic signed [15:0] mem_x;
    logic signed [15:0] mem_y;
    logic               s_ready;
    logic               s_done;
    logic [1:0]         s_sel;
    logic signed [15:0] s_x1;
    logic signed [15:0] s_y1;
    logic signed [15:0] s_x2;
    logic signed [15:0] s_y2;
    logic [7:0]         s_data_out;
    logic [1:0]         res_sel;
    logic [7:0]         res_out;
`ifdef KNN_CTRL_ABORT_EN
    logic               abort;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic signed [15:0] tbl_x [256];
    logic signed [15:0] tbl_y [256];
    logic [7:0]         sort_base;

    // Recorder results of the most recent run()
    int                 rd_cyc [$];
    logic [7:0]         rd_addr [$];
    int                 push_cyc [$];
    logic signed [15:0] push_x [$];
    logic signed [15:0] push_y [$];
    logic [1:0]         sel_log [$];
    int                 done_cyc;
    int                 done_cnt;
    int                 overlap;
    int                 x1_bad;
    logic               busy_after;

    knn_ctrl dut (
        .clk        (clk),
        .rst        (rst),
`ifdef KNN_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .n_points   (n_points),
        .test_x     (test_x),
        .test_y     (test_y),
        .busy       (busy),
        .done       (done),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_x      (mem_x),
        .mem_y      (mem_y),
        .s_ready    (s_ready),
        .s_done     (s_done),
        .s_sel      (s_sel),
        .s_x1       (s_x1),
        .s_y1       (s_y1),
        .s_x2       (s_x2),
        .s_y2       (s_y2),
        .s_data_out (s_data_out),
        .res_sel    (res_sel),
        .res_out    (res_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_x <= tbl_x[mem_addr];
            mem_y <= tbl_y[mem_addr];
        end
    end

    assign s_data_out = sort_base + {6'd0, s_sel};

    // Drives one run from IDLE and logs what the DUT does each cycle until one cycle after done
    // (or max_c). If restart_at>0, start is pulsed again in that cycle with a different N.
    task automatic run(input logic [7:0] n, input logic signed [15:0] tx, input logic signed [15:0] ty,
                       input int restart_at, input int max_c);
        rd_cyc.delete(); rd_addr.delete(); push_cyc.delete(); push_x.delete(); push_y.delete();
        sel_log.delete();
        done_cyc = 0; done_cnt = 0; overlap = 0; x1_bad = 0; busy_after = 1'b1;
        start = 1'b1; n_points = n; test_x = tx; test_y = ty;
        for (int c = 2; c <= max_c; c++) begin
            @(posedge clk); #1;
            if (c == restart_at) begin
                start = 1'b1; n_points = 8'd7;
            end else begin
                start = 1'b0;
            end
            if (mem_rd) begin
                rd_cyc.push_back(c); rd_addr.push_back(mem_addr);
            end
            if (s_ready) begin
                push_cyc.push_back(c); push_x.push_back(s_x2); push_y.push_back(s_y2);
                if (s_x1 !== tx || s_y1 !== ty) x1_bad++;
            end
            if (s_done) sel_log.push_back(s_sel);
            if (s_ready && s_done) overlap++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (done_cyc != 0 && c == done_cyc + 1) begin
                busy_after = busy;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; n_points = 8'd0; test_x = 16'sd0; test_y = 16'sd0; res_sel = 2'd0;
        sort_base = 8'h00;
`ifdef KNN_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done, mem_rd, s_ready, s_done} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_rd, s_ready, s_done});
        end
        n_vec++;
        if ({mem_addr, s_sel, s_x1, s_y1, s_x2, s_y2} !== 74'd0) begin
            n_err++; $display("FAIL reset_data: addr=%0d sel=%0d x1=%0d y1=%0d x2=%0d y2=%0d want all 0",
                              mem_addr, s_sel, s_x1, s_y1, s_x2, s_y2);
        end
        for (int s = 0; s < 4; s++) begin
            res_sel = 2'(s); #1;
            n_vec++;
            if (res_out !== 8'h00) begin
                n_err++; $display("FAIL reset_res[%0d]: got %h want 00", s, res_out);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        logic signed [15:0] ex [3];
        logic signed [15:0] ey [3];
        ex[0] = 16'sd1;  ey[0] = 16'sd1;
        ex[1] = 16'sd7;  ey[1] = -16'sd3;
        ex[2] = -16'sd4; ey[2] = 16'sd9;
        for (int k = 0; k < 3; k++) begin
            tbl_x[k] = ex[k]; tbl_y[k] = ey[k];
        end
        sort_base = 8'h10;
        run(8'd3, 16'sd5, -16'sd2, 0, 40);
        n_vec++;
        if (rd_addr.size() != 3) begin
            n_err++; $display("FAIL basic_rd_count: got %0d want 3", rd_addr.size());
        end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (k >= rd_addr.size() || rd_addr[k] !== 8'(k) || rd_cyc[k] != 2 + 3 * k) begin
                n_err++; $display("FAIL basic_addr[%0d]: want addr %0d in cycle %0d", k, k, 2 + 3 * k);
            end
        end
        n_vec++;
        if (push_x.size() != 3) begin
            n_err++; $display("FAIL basic_push_count: got %0d want 3", push_x.size());
        end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (k >= push_x.size() || push_x[k] !== ex[k] || push_y[k] !== ey[k] || push_cyc[k] != 4 + 3 * k) begin
                n_err++; $display("FAIL basic_push[%0d]: want (%0d,%0d) in cycle %0d", k, ex[k], ey[k], 4 + 3 * k);
            end
        end
        n_vec++;
        if (x1_bad != 0) begin
            n_err++; $display("FAIL basic_test_pt: got %0d bad pushes want 0", x1_bad);
        end
        n_vec++;
        if (sel_log.size() != 4 || sel_log[0] !== 2'd0 || sel_log[1] !== 2'd1 || sel_log[2] !== 2'd2 || sel_log[3] !== 2'd3) begin
            n_err++; $display("FAIL basic_sel: got %0d s_done cycles want 4 with sel 0..3", sel_log.size());
        end
        n_vec++;
        if (overlap != 0) begin
            n_err++; $display("FAIL basic_overlap: got %0d want 0", overlap);
        end
        n_vec++;
        if (done_cyc != 15 || done_cnt != 1) begin
            n_err++; $display("FAIL basic_done: got cycle %0d count %0d want cycle 15 count 1", done_cyc, done_cnt);
        end
        n_vec++;
        if (busy_after !== 1'b0) begin
            n_err++; $display("FAIL basic_busy_after: got %b want 0", busy_after);
        end
        // Results must hold while idle even though the sorter output changes.
        repeat (5) @(posedge clk);
        sort_base = 8'h77;
        #1;
        for (int s = 0; s < 4; s++) begin
            res_sel = 2'(s); #1;
            n_vec++;
            if (res_out !== 8'h10 + 8'(s)) begin
                n_err++; $display("FAIL basic_res[%0d]: got %h want %h", s, res_out, 8'h10 + 8'(s));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_n0();
        sort_base = 8'h30;
        run(8'd0, 16'sd0, 16'sd0, 0, 20);
        n_vec++;
        if (rd_addr.size() != 0 || push_x.size() != 0) begin
            n_err++; $display("FAIL n0_traffic: got %0d reads %0d pushes want 0 0", rd_addr.size(), push_x.size());
        end
        n_vec++;
        if (sel_log.size() != 4 || sel_log[0] !== 2'd0 || sel_log[1] !== 2'd1 || sel_log[2] !== 2'd2 || sel_log[3] !== 2'd3) begin
            n_err++; $display("FAIL n0_sel: got %0d s_done cycles want 4 with sel 0..3", sel_log.size());
        end
        n_vec++;
        if (done_cyc != 6 || done_cnt != 1) begin
            n_err++; $display("FAIL n0_done: got cycle %0d count %0d want cycle 6 count 1", done_cyc, done_cnt);
        end
        for (int s = 0; s < 4; s++) begin
            res_sel = 2'(s); #1;
            n_vec++;
            if (res_out !== 8'h30 + 8'(s)) begin
                n_err++; $display("FAIL n0_res[%0d]: got %h want %h", s, res_out, 8'h30 + 8'(s));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        for (int k = 0; k < 8; k++) begin
            tbl_x[k] = 16'(100 + k); tbl_y[k] = 16'(-k);
        end
        run(8'd5, 16'sd3, 16'sd4, 6, 60);
        n_vec++;
        if (push_x.size() != 5) begin
            n_err++; $display("FAIL ignore_push_count: got %0d want 5", push_x.size());
        end
        n_vec++;
        if (done_cyc != 21 || done_cnt != 1) begin
            n_err++; $display("FAIL ignore_done: got cycle %0d count %0d want cycle 21 count 1", done_cyc, done_cnt);
        end
        n_vec++;
        if (busy_after !== 1'b0) begin
            n_err++; $display("FAIL ignore_busy_after: got %b want 0", busy_after);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_n255();
        for (int k = 0; k < 256; k++) begin
            tbl_x[k] = 16'(k); tbl_y[k] = 16'(1000 - k);
        end
        run(8'd255, 16'sd0, 16'sd0, 0, 800);
        n_vec++;
        if (push_x.size() != 255 || rd_addr.size() != 255) begin
            n_err++; $display("FAIL n255_count: got %0d pushes %0d reads want 255 255", push_x.size(), rd_addr.size());
        end
        n_vec++;
        if (push_x.size() != 255 || push_x[254] !== 16'sd254 || push_y[254] !== 16'sd746 || rd_addr[254] !== 8'd254) begin
            n_err++; $display("FAIL n255_last: want point 254 = (254,746) from addr 254");
        end
        n_vec++;
        if (done_cyc != 771 || done_cnt != 1) begin
            n_err++; $display("FAIL n255_done: got cycle %0d count %0d want cycle 771 count 1", done_cyc, done_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int dn;
        int bz;
        start = 1'b1; n_points = 8'd4; test_x = 16'sd9; test_y = -16'sd9;
        for (int c = 2; c <= 7; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        n_vec++;
        if (s_ready !== 1'b1) begin
            n_err++; $display("FAIL rstmid_push2: s_ready got %b want 1", s_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, mem_rd, s_ready, s_done} !== 5'b0 || {mem_addr, s_sel, s_x1, s_y1, s_x2, s_y2} !== 74'd0) begin
            n_err++; $display("FAIL rstmid_async: ctrl=%b addr=%0d sel=%0d x1=%0d x2=%0d want all 0",
                              {busy, done, mem_rd, s_ready, s_done}, mem_addr, s_sel, s_x1, s_x2);
        end
        for (int s = 0; s < 4; s++) begin
            res_sel = 2'(s); #1;
            n_vec++;
            if (res_out !== 8'h00) begin
                n_err++; $display("FAIL rstmid_res[%0d]: got %h want 00", s, res_out);
            end
        end
        @(posedge clk); #3 rst = 1'b0;
        dn = 0; bz = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) dn++;
            if (busy) bz++;
        end
        n_vec++;
        if (dn != 0 || bz != 0) begin
            n_err++; $display("FAIL rstmid_quiet: got %0d done %0d busy cycles want 0 0", dn, bz);
        end
        sort_base = 8'h40;
        tbl_x[0] = -16'sd50; tbl_y[0] = 16'sd60;
        run(8'd1, 16'sd2, 16'sd2, 0, 30);
        n_vec++;
        if (done_cyc != 9 || done_cnt != 1 || push_x.size() != 1 || push_x[0] !== -16'sd50 || push_y[0] !== 16'sd60) begin
            n_err++; $display("FAIL rstmid_rerun: got done cycle %0d pushes %0d want cycle 9 one push (-50,60)",
                              done_cyc, push_x.size());
        end
        for (int s = 0; s < 4; s++) begin
            res_sel = 2'(s); #1;
            n_vec++;
            if (res_out !== 8'h40 + 8'(s)) begin
                n_err++; $display("FAIL rstmid_newres[%0d]: got %h want %h", s, res_out, 8'h40 + 8'(s));
            end
        end
        @(posedge clk); #1;
    endtask

`ifdef KNN_CTRL_ABORT_EN
    task automatic test_abort();
        int dn;
        sort_base = 8'h66;
        start = 1'b1; n_points = 8'd10; test_x = 16'sd1; test_y = 16'sd1;
        for (int c = 2; c <= 8; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_vec++;
        if ({busy, done, mem_rd, s_ready, s_done} !== 5'b0) begin
            n_err++; $display("FAIL abort_idle: got %b want 00000", {busy, done, mem_rd, s_ready, s_done});
        end
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done || busy) dn++;
        end
        n_vec++;
        if (dn != 0) begin
            n_err++; $display("FAIL abort_quiet: got %0d done/busy cycles want 0", dn);
        end
        for (int s = 0; s < 4; s++) begin
            res_sel = 2'(s); #1;
            n_vec++;
            if (res_out !== 8'h40 + 8'(s)) begin
                n_err++; $display("FAIL abort_res[%0d]: got %h want %h", s, res_out, 8'h40 + 8'(s));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_n0();
        test_ignore_start();
        test_n255();
        test_reset_mid();
`ifdef KNN_CTRL_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
